// File: rtl/rv_core_pkg.sv
// Shared core types for the writeback scheduler: widths, source ids and
// the writeback request bundle presented by each source.
package rv_core_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REGW = $clog2(NREG);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // The source that is not s; used to advance the round-robin pointer.
  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way writeback arbiter. One grant per cycle; when both sources are
// valid, RR_ARB=1 honours the round-robin pointer and RR_ARB=0 favours ALU.
module wb_rr_arbiter
  import rv_core_pkg::*;
#(
  parameter bit RR_ARB = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic grant_valid,
  output src_e grant_src
);

  src_e rr_ptr;

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    grant_valid = reset_n && (alu_valid || mem_valid);
    grant_src   = SRC_ALU;
    if (alu_valid && mem_valid) begin
      grant_src = RR_ARB ? rr_ptr : SRC_ALU;
    end else if (mem_valid) begin
      grant_src = SRC_MEM;
    end
  end

  // Pointer moves to the other source after any grant, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      rr_ptr <= SRC_ALU;
    end else if (grant_valid) begin
      rr_ptr <= other_src(grant_src);
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Schedules the single register-file write port between ALU and load
// writeback, keeps a per-register busy scoreboard and stalls decode on
// RAW/WAW hazards against in-flight destinations.
module regfile_wb_scheduler
  import rv_core_pkg::*;
#(
  parameter bit RR_ARB = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            issue_valid,
  input  logic [REGW-1:0] issue_rs1,
  input  logic [REGW-1:0] issue_rs2,
  input  logic [REGW-1:0] issue_rd,
  input  logic            issue_wr,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic [REGW-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [REGW-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            wb_regwrite,
  output logic [REGW-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data
);

  wb_req_t         alu_req;
  wb_req_t         mem_req;
  wb_req_t         sel_req;
  logic            grant_valid;
  src_e            grant_src;
  logic            wb_write_next;
  logic            issue_accept;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  wb_rr_arbiter #(
    .RR_ARB(RR_ARB)
  ) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_valid  (alu_valid),
    .mem_valid  (mem_valid),
    .grant_valid(grant_valid),
    .grant_src  (grant_src)
  );

  // Bundle source requests, pick the granted one and drive ready back.
  always_comb begin
    alu_req       = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    mem_req       = '{valid: mem_valid, rd: mem_rd, data: mem_data};
    sel_req       = (grant_src == SRC_MEM) ? mem_req : alu_req;
    alu_ready     = grant_valid && (grant_src == SRC_ALU);
    mem_ready     = grant_valid && (grant_src == SRC_MEM);
    // A granted write to x0 completes the handshake but never reaches the file.
    wb_write_next = grant_valid && sel_req.valid && (sel_req.rd != '0);
  end

  // Hazard detection against current busy bits only; no same-cycle bypass.
  always_comb begin
    issue_stall  = issue_valid &&
                   (busy[issue_rs1] || busy[issue_rs2] || (issue_wr && busy[issue_rd]));
    issue_accept = issue_valid && !issue_stall && issue_wr && (issue_rd != '0);
  end

  // Scoreboard update: clear the retiring rd, then set the newly issued rd
  // so a same-index set wins over the clear.
  always_comb begin
    busy_next = busy;
    if (wb_regwrite) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (issue_accept) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register; flushed on reset together with in-flight state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the busy array is reset because a stale bit after reset would
      // stall decode forever; plain data storage would not need this.
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Writeback output registers; rd/data hold their last value when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      wb_regwrite <= wb_write_next;
      if (wb_write_next) begin
        wb_rd   <= sel_req.rd;
        wb_data <= sel_req.data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: one round-robin instance and one
// fixed-priority instance share all inputs.
module tb_regfile_wb_scheduler;
  import rv_core_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            issue_valid;
  logic [REGW-1:0] issue_rs1, issue_rs2, issue_rd;
  logic            issue_wr;
  logic            alu_valid, mem_valid;
  logic [REGW-1:0] alu_rd, mem_rd;
  logic [XLEN-1:0] alu_data, mem_data;

  logic            issue_stall, alu_ready, mem_ready, wb_regwrite;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            fp_issue_stall, fp_alu_ready, fp_mem_ready, fp_wb_regwrite;
  logic [REGW-1:0] fp_wb_rd;
  logic [XLEN-1:0] fp_wb_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.RR_ARB(1'b1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  regfile_wb_scheduler #(.RR_ARB(1'b0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_stall(fp_issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(fp_alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(fp_mem_ready),
    .wb_regwrite(fp_wb_regwrite), .wb_rd(fp_wb_rd), .wb_data(fp_wb_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_wr = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic set_issue(input logic [REGW-1:0] rs1, input logic [REGW-1:0] rs2,
                           input logic [REGW-1:0] rd, input logic wr);
    issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_wr = wr;
  endtask

  // T1: reset at start and mid-stream with both sources valid.
  task automatic test_reset();
    idle();
    reset_n   = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3;
    mem_valid = 1'b1; mem_rd = 5'd4;
    #1;
    checks++;
    if ({alu_ready, mem_ready, wb_regwrite, issue_stall} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_init_ctrl got=%b exp=0000", {alu_ready, mem_ready, wb_regwrite, issue_stall});
    end
    checks++;
    if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_init_wb rd=%0d data=%h exp 0/0", wb_rd, wb_data);
    end
    tick(); tick();
    reset_n = 1'b1;
    idle();
    // Busy x7 via issue and put a write of x5 into the output registers.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_0055;
    set_issue(5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0044;
    set_issue(5'd7, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (issue_stall !== 1'b1 || wb_regwrite !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_state stall=%b regwrite=%b exp 1/1", issue_stall, wb_regwrite);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({alu_ready, mem_ready, wb_regwrite, issue_stall} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_ctrl got=%b exp=0000", {alu_ready, mem_ready, wb_regwrite, issue_stall});
    end
    checks++;
    if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_wb rd=%0d data=%h exp 0/0", wb_rd, wb_data);
    end
    tick();
    reset_n = 1'b1;
    idle();
    set_issue(5'd7, 5'd7, 5'd7, 1'b1);
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_flushed stall=%b exp=0", issue_stall);
    end
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // T3: both sources valid for four cycles, pointer starts at ALU.
  task automatic test_arbitration();
    logic [3:0] exp_mem;
    exp_mem = 4'b1010;  // bit i: cycle i grants MEM in round-robin mode
    idle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA0A0_0003;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB0B0_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (alu_ready !== !exp_mem[i] || mem_ready !== exp_mem[i]) begin
        failures++;
        $display("FAIL rr_grant cyc=%0d alu_ready=%b mem_ready=%b exp_mem=%b", i, alu_ready, mem_ready, exp_mem[i]);
      end
      checks++;
      if (fp_alu_ready !== 1'b1 || fp_mem_ready !== 1'b0) begin
        failures++;
        $display("FAIL fp_grant cyc=%0d alu_ready=%b mem_ready=%b exp 1/0", i, fp_alu_ready, fp_mem_ready);
      end
      tick();
      checks++;
      if (wb_regwrite !== 1'b1 || wb_rd !== (exp_mem[i] ? 5'd4 : 5'd3) ||
          wb_data !== (exp_mem[i] ? 32'hB0B0_0004 : 32'hA0A0_0003)) begin
        failures++;
        $display("FAIL rr_wb cyc=%0d regwrite=%b rd=%0d data=%h exp_mem=%b", i, wb_regwrite, wb_rd, wb_data, exp_mem[i]);
      end
      checks++;
      if (fp_wb_regwrite !== 1'b1 || fp_wb_rd !== 5'd3 || fp_wb_data !== 32'hA0A0_0003) begin
        failures++;
        $display("FAIL fp_wb cyc=%0d regwrite=%b rd=%0d data=%h exp 1/3/a0a00003", i, fp_wb_regwrite, fp_wb_rd, fp_wb_data);
      end
    end
    idle();
    tick();
  endtask

  // T2: single ALU writeback, one-cycle latency, then hold when idle.
  task automatic test_single_alu();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL alu_ready got=%b/%b exp 1/0", alu_ready, mem_ready);
    end
    tick();
    idle();
    checks++;
    if (wb_regwrite !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL alu_wb regwrite=%b rd=%0d data=%h exp 1/5/deadbeef", wb_regwrite, wb_rd, wb_data);
    end
    tick();
    checks++;
    if (wb_regwrite !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL idle_hold regwrite=%b rd=%0d data=%h exp 0/5/deadbeef", wb_regwrite, wb_rd, wb_data);
    end
  endtask

  // T4: RAW stall on x7 until the cycle after its writeback.
  task automatic test_raw_stall();
    idle();
    set_issue(5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL raw_first_issue stall=%b exp=0", issue_stall);
    end
    tick();
    set_issue(5'd7, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin
      failures++;
      $display("FAIL raw_stall_c1 stall=%b exp=1", issue_stall);
    end
    tick();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0777;
    #1;
    checks++;
    if (issue_stall !== 1'b1 || alu_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_grant_cycle stall=%b alu_ready=%b exp 1/1", issue_stall, alu_ready);
    end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++;
    if (issue_stall !== 1'b1 || wb_regwrite !== 1'b1 || wb_rd !== 5'd7) begin
      failures++;
      $display("FAIL raw_wb_cycle stall=%b regwrite=%b rd=%0d exp 1/1/7", issue_stall, wb_regwrite, wb_rd);
    end
    tick();
    checks++;
    if (issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL raw_released stall=%b exp=0", issue_stall);
    end
    idle();
    tick();
  endtask

  // T5: writeback to x0 completes the handshake but never writes; x0 never stalls.
  task automatic test_x0();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    set_issue(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (alu_ready !== 1'b1 || issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL x0_handshake alu_ready=%b stall=%b exp 1/0", alu_ready, issue_stall);
    end
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_5678;
    set_issue(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (wb_regwrite !== 1'b0 || issue_stall !== 1'b0 || mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_no_write regwrite=%b stall=%b mem_ready=%b exp 0/0/1", wb_regwrite, issue_stall, mem_ready);
    end
    tick();
    idle();
    checks++;
    if (wb_regwrite !== 1'b0) begin
      failures++;
      $display("FAIL x0_mem_no_write regwrite=%b exp=0", wb_regwrite);
    end
    tick();
  endtask

  // T6: issue of x9 in the same cycle x9 retires -> set wins, later read stalls.
  task automatic test_set_wins();
    idle();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000_0099;
    #1;
    checks++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      failures++;
      $display("FAIL mem_ready got=%b/%b exp 1/0", mem_ready, alu_ready);
    end
    tick();
    idle();
    set_issue(5'd0, 5'd0, 5'd9, 1'b1);
    #1;
    checks++;
    if (wb_regwrite !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'h0000_0099 || issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL set_wins_edge regwrite=%b rd=%0d data=%h stall=%b exp 1/9/99/0", wb_regwrite, wb_rd, wb_data, issue_stall);
    end
    tick();
    set_issue(5'd0, 5'd9, 5'd0, 1'b0);
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin
      failures++;
      $display("FAIL set_wins_busy stall=%b exp=1", issue_stall);
    end
    tick();
    checks++;
    if (issue_stall !== 1'b1) begin
      failures++;
      $display("FAIL set_wins_hold stall=%b exp=1", issue_stall);
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single_alu();
    test_raw_stall();
    test_x0();
    test_set_wins();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
